anim_sched: RTL and testbench

- Scheduler/sequencer for the 8-LED animation datapath: generates the step tick, walks a step counter through one of four selectable patterns and drives the LED word.
- Accepts mode-change requests at any time and applies them only at a frame boundary, so a pattern is never cut mid-frame.
- Pause and run controls freeze or halt sequencing.
- Sits between the board/user-control logic and the LED pins.

---
 rtl/anim_sched.sv | 184 ++++++++++++++++++
 tb/tb_anim_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_sched.sv
// Step/frame scheduler for the 8-LED animation: prescaled step tick, four patterns,
// frame-boundary mode changes. Define ANIM_PWM_EN to add 3-bit PWM brightness on led.
module anim_sched #(
   parameter int DIV_W = 24,
   parameter int N_LED = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             pause,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       mode_req,
   input  logic             mode_req_valid,
   input  logic [2:0]       bright,
   output logic             mode_ack,
   output logic [1:0]       mode,
   output logic             step_tick,
   output logic             frame_done,
   output logic             busy,
   output logic [N_LED-1:0] led
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] PRESC_ONE = DIV_W'(1);

   // LED word for step k of pattern m.
   function automatic logic [N_LED-1:0] pattern(input logic [1:0] m, input logic [3:0] k);
      logic [15:0] p;
      p = '0;
      case (m)
         2'd0:    p = k[3] ? (16'd1 << (4'd15 - k)) - 16'd1 : (16'd2 << k) - 16'd1;
         2'd1:    p = 16'd1 << k[2:0];
         2'd2:    p = k[3] ? 16'd1 << (4'd14 - k) : 16'd1 << k[2:0];
         default: p = (k == 4'd0) ? 16'hFFFF : 16'h0000;
      endcase
      return p[N_LED-1:0];
   endfunction

   function automatic logic [3:0] last_step(input logic [1:0] m);
      case (m)
         2'd0:    return 4'd15;
         2'd1:    return 4'd7;
         2'd2:    return 4'd13;
         default: return 4'd1;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [3:0]       step_q, step_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [DIV_W-1:0] div_lat_q, div_lat_d;
   logic [1:0]       pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic             ack_q, ack_d;
   logic [N_LED-1:0] led_q, led_d;

   // NOTE: every signal gets its default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      step_d     = step_q;
      presc_d    = presc_q;
      div_lat_d  = div_lat_q;
      pend_d     = pend_q;
      pend_v_d   = pend_v_q;
      led_d      = led_q;
      ack_d      = 1'b0;
      step_tick  = 1'b0;
      frame_done = 1'b0;

      unique case (state_q)
         IDLE: begin
            presc_d = '0;
            step_d  = '0;
            led_d   = '0;
            // No frame in flight, so requests (new or left pending) apply at once.
            if (mode_req_valid) begin
               mode_d   = mode_req;
               pend_v_d = 1'b0;
               ack_d    = 1'b1;
            end else if (pend_v_q) begin
               mode_d   = pend_q;
               pend_v_d = 1'b0;
               ack_d    = 1'b1;
            end
            if (run) begin
               state_d   = RUN;
               div_lat_d = div;
               led_d     = pattern(mode_d, 4'd0);
            end
         end

         RUN, HOLD: begin
            if (mode_req_valid) begin
               pend_d   = mode_req;
               pend_v_d = 1'b1;
            end
            if (!run) begin
               state_d = IDLE;
               presc_d = '0;
               step_d  = '0;
               led_d   = '0;
            end else if (state_q == HOLD) begin
               if (!pause) state_d = RUN;
            end else if (pause) begin
               state_d = HOLD;
            end else if (presc_q == div_lat_q) begin
               step_tick = 1'b1;
               presc_d   = '0;
               if (step_q == last_step(mode_q)) begin
                  frame_done = 1'b1;
                  step_d     = '0;
                  div_lat_d  = div;
                  // Only a request pending before this edge is applied; one arriving now waits.
                  if (pend_v_q) begin
                     mode_d = pend_q;
                     ack_d  = 1'b1;
                     if (!mode_req_valid) pend_v_d = 1'b0;
                  end
               end else begin
                  step_d = step_q + 4'd1;
               end
               led_d = pattern(mode_d, step_d);
            end else begin
               presc_d = presc_q + PRESC_ONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mode_q    <= '0;
         step_q    <= '0;
         presc_q   <= '0;
         div_lat_q <= '0;
         pend_q    <= '0;
         pend_v_q  <= 1'b0;
         ack_q     <= 1'b0;
         led_q     <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         step_q    <= step_d;
         presc_q   <= presc_d;
         div_lat_q <= div_lat_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
         ack_q     <= ack_d;
         led_q     <= led_d;
      end
   end

   assign mode     = mode_q;
   assign mode_ack = ack_q;
   assign busy     = (state_q != IDLE);

`ifdef ANIM_PWM_EN
   logic [2:0] pwm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  pwm_q <= '0;
      else if (state_q == IDLE) pwm_q <= '0;
      else                      pwm_q <= pwm_q + 3'd1;
   end

   assign led = led_q & {N_LED{pwm_q < bright}};
`else
   logic unused_bright;
   assign unused_bright = ^bright;
   assign led           = led_q;
`endif

endmodule

// File: tb/tb_anim_sched.sv
// Self-checking bench for anim_sched: table of per-mode frames plus hand sequences for
// boundary mode changes, pause, run drop and mid-frame reset; LED steps go through a scoreboard.
module tb_anim_sched;

   localparam int DIV_W = 24;
   localparam int N_LED = 8;
`ifdef ANIM_PWM_EN
   localparam int EXP_HALF  = 4;
   localparam int EXP_BLANK = 0;
`else
   localparam int EXP_HALF  = 8;
   localparam int EXP_BLANK = 8;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic             pause;
   logic [DIV_W-1:0] div;
   logic [1:0]       mode_req;
   logic             mode_req_valid;
   logic [2:0]       bright;
   logic             mode_ack;
   logic [1:0]       mode;
   logic             step_tick;
   logic             frame_done;
   logic             busy;
   logic [N_LED-1:0] led;

   anim_sched #(.DIV_W(DIV_W), .N_LED(N_LED)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .pause          (pause),
      .div            (div),
      .mode_req       (mode_req),
      .mode_req_valid (mode_req_valid),
      .bright         (bright),
      .mode_ack       (mode_ack),
      .mode           (mode),
      .step_tick      (step_tick),
      .frame_done     (frame_done),
      .busy           (busy),
      .led            (led)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] led;
      logic       fd;
   } exp_t;

   typedef struct {
      logic [1:0]       mode;
      int               dv;
      int               len;
      logic [15:0][7:0] leds;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[4];
   int   checks   = 0;
   int   failures = 0;
   int   ack_cnt  = 0;
   int   n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] l, input logic fd);
      exp_t e;
      e.led = l;
      e.fd  = fd;
      sb.push_back(e);
   endtask

   // One clock: sample tick/frame_done before the edge, compare the stepped led after it.
   task automatic cyc();
      logic t, f;
      exp_t e;
      @(negedge clk);
      t = step_tick;
      f = frame_done;
      @(posedge clk);
      #1;
      if (mode_ack) ack_cnt++;
      if (t) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tick actual=tick led=0x%0h required=no tick", led);
         end else begin
            e = sb.pop_front();
            check("sb_led", 32'(led), 32'(e.led));
            check("sb_frame_done", 32'(f), 32'(e.fd));
         end
      end
   endtask

   task automatic set_mode_idle(input logic [1:0] m);
      mode_req       = m;
      mode_req_valid = 1'b1;
      cyc();
      mode_req_valid = 1'b0;
      check("idle_req_mode", 32'(mode), 32'(m));
      check("idle_req_ack", 32'(mode_ack), 32'd1);
      cyc();
      check("idle_ack_pulse", 32'(mode_ack), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{mode: 2'd0, dv: 3, len: 16, leds: 128'h00010307_0F1F3F7F_FF7F3F1F_0F070301};
      tbl[1] = '{mode: 2'd1, dv: 1, len: 8,  leds: 128'h00000000_00000000_80402010_08040201};
      tbl[2] = '{mode: 2'd2, dv: 0, len: 14, leds: 128'h00000204_08102040_80402010_08040201};
      tbl[3] = '{mode: 2'd3, dv: 2, len: 2,  leds: 128'h00000000_00000000_00000000_000000FF};

      rst = 1'b1; run = 1'b0; pause = 1'b0; div = '0;
      mode_req = 2'd0; mode_req_valid = 1'b0; bright = 3'd7;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_ack", 32'(mode_ack), 32'd0);
      check("rst_tick", 32'(step_tick), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b0;

      // Two full frames of every pattern at different tick periods.
      for (int r = 0; r < 4; r++) begin
         set_mode_idle(tbl[r].mode);
         for (int f = 0; f < 2; f++)
            for (int i = 0; i < tbl[r].len; i++)
               push(tbl[r].leds[(i + 1) % tbl[r].len], i == tbl[r].len - 1);
         div = DIV_W'(tbl[r].dv);
         run = 1'b1;
         cyc();
         check("tbl_entry_led", 32'(led), 32'(tbl[r].leds[0]));
         check("tbl_busy", 32'(busy), 32'd1);
         repeat (2 * tbl[r].len * (tbl[r].dv + 1)) cyc();
         run = 1'b0;
         cyc();
         check("tbl_drain", 32'(sb.size()), 32'd0);
         check("tbl_idle", 32'(busy), 32'd0);
      end

      // Request mode 2 at step 5 of mode 0: applied only at the wrap.
      set_mode_idle(2'd0);
      ack_cnt = 0;
      for (int j = 1; j < 16; j++) push(tbl[0].leds[j], 1'b0);
      push(8'h01, 1'b1);
      for (int j = 1; j < 14; j++) push(tbl[2].leds[j], 1'b0);
      push(8'h01, 1'b1);
      div = '0;
      run = 1'b1;
      cyc();
      check("b_entry_led", 32'(led), 32'h01);
      for (int j = 1; j <= 30; j++) begin
         cyc();
         if (j == 15) begin
            check("b_mode_before_wrap", 32'(mode), 32'd0);
            check("b_no_early_ack", 32'(ack_cnt), 32'd0);
         end
         if (j == 16) begin
            check("b_mode_after_wrap", 32'(mode), 32'd2);
            check("b_ack_after_wrap", 32'(mode_ack), 32'd1);
         end
         if (j == 17) check("b_ack_pulse", 32'(mode_ack), 32'd0);
         mode_req       = 2'd2;
         mode_req_valid = (j == 5);
      end
      run = 1'b0;
      cyc();
      check("b_drain", 32'(sb.size()), 32'd0);

      // Requests 1 then 3 in one frame; then a request in the wrap cycle waits a frame.
      ack_cnt = 0;
      for (int j = 1; j < 14; j++) push(tbl[2].leds[j], 1'b0);
      push(8'hFF, 1'b1); push(8'h00, 1'b0); push(8'hFF, 1'b1);
      push(8'h00, 1'b0); push(8'h01, 1'b1);
      run = 1'b1;
      cyc();
      check("c_entry_led", 32'(led), 32'h01);
      for (int j = 1; j <= 18; j++) begin
         cyc();
         if (j == 15) begin
            check("c_single_ack", 32'(ack_cnt), 32'd1);
            check("c_latest_wins", 32'(mode), 32'd3);
         end
         if (j == 17) begin
            check("c_wrap_req_waits_mode", 32'(mode), 32'd3);
            check("c_wrap_req_waits_ack", 32'(ack_cnt), 32'd1);
         end
         if (j == 18) begin
            check("c_next_wrap_mode", 32'(mode), 32'd1);
            check("c_next_wrap_ack", 32'(ack_cnt), 32'd2);
         end
         mode_req       = (j == 5) ? 2'd3 : 2'd1;
         mode_req_valid = (j == 2) || (j == 5) || (j == 15);
      end
      run = 1'b0;
      cyc();
      check("c_drain", 32'(sb.size()), 32'd0);

      // Pause for 10 cycles with the prescaler at 2 of 5.
      push(8'h02, 1'b0);
      push(8'h04, 1'b0);
      div = DIV_W'(5);
      run = 1'b1;
      cyc();
      check("d_entry_led", 32'(led), 32'h01);
      for (int j = 1; j <= 23; j++) begin
         cyc();
         if (j >= 9 && j <= 18) begin
            check("d_hold_tick", 32'(step_tick), 32'd0);
            check("d_hold_led", 32'(led), 32'h02);
            check("d_hold_busy", 32'(busy), 32'd1);
         end
         if (j == 21) check("d_no_early_tick", 32'(step_tick), 32'd0);
         if (j == 22) check("d_resume_tick", 32'(step_tick), 32'd1);
         pause = (j >= 8 && j <= 17);
      end
      run = 1'b0;
      cyc();
      check("d_drain", 32'(sb.size()), 32'd0);

      // Drop run at step 9, then restart from step 0 in the same mode.
      set_mode_idle(2'd0);
      for (int j = 1; j <= 9; j++) push(tbl[0].leds[j], 1'b0);
      div = '0;
      run = 1'b1;
      cyc();
      repeat (9) cyc();
      run = 1'b0;
      cyc();
      check("e_idle_led", 32'(led), 32'h00);
      check("e_idle_busy", 32'(busy), 32'd0);
      check("e_idle_mode", 32'(mode), 32'd0);
      check("e_drain", 32'(sb.size()), 32'd0);
      cyc();
      run = 1'b1;
      push(8'h03, 1'b0);
      cyc();
      check("e_restart_led", 32'(led), 32'h01);
      cyc();
      run = 1'b0;
      cyc();
      check("e_restart_drain", 32'(sb.size()), 32'd0);

      // Reset mid-frame with a request pending (strobed on a wrap cycle).
      set_mode_idle(2'd3);
      push(8'h00, 1'b0); push(8'hFF, 1'b1); push(8'h00, 1'b0);
      run = 1'b1;
      cyc();
      cyc();
      mode_req       = 2'd1;
      mode_req_valid = 1'b1;
      cyc();
      mode_req_valid = 1'b0;
      cyc();
      #2;
      rst = 1'b1;
      run = 1'b0;
      #1;
      check("f_rst_mode", 32'(mode), 32'd0);
      check("f_rst_busy", 32'(busy), 32'd0);
      check("f_rst_led", 32'(led), 32'h00);
      check("f_rst_ack", 32'(mode_ack), 32'd0);
      check("f_rst_drain", 32'(sb.size()), 32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      ack_cnt = 0;
      repeat (6) cyc();
      check("f_pending_discarded", 32'(ack_cnt), 32'd0);
      check("f_mode_after_rst", 32'(mode), 32'd0);

      // Brightness on blink step 0 (tick period far longer than the window).
      set_mode_idle(2'd3);
      div    = DIV_W'(100);
      bright = 3'd4;
      run    = 1'b1;
      cyc();
      n = 0;
      repeat (8) begin
         cyc();
         if (led == 8'hFF) n++;
      end
      check("pwm_half_duty", 32'(n), 32'(EXP_HALF));
      bright = 3'd0;
      n = 0;
      repeat (8) begin
         cyc();
         if (led == 8'hFF) n++;
      end
      check("pwm_blank", 32'(n), 32'(EXP_BLANK));
      run = 1'b0;
      cyc();
      check("pwm_drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
